// File: rtl/tl_a_repeater.sv
// tl_a_repeater: single-entry TileLink A-channel repeater.
// Beats pass through combinationally. A beat accepted with repeat_i high is
// captured and replayed until a handshake with repeat_i low releases it.
// Ports:
//   clock_i, reset_n_i   clock, synchronous active-low reset
//   repeat_i             hold the current beat (sampled on deq handshake only)
//   enq_*_i / enq_ready_o  upstream beat and handshake
//   deq_*_o / deq_ready_i  downstream beat and handshake
//   full_o               a captured beat is being replayed
//   saved_mask_o         mask of the captured beat, 0 when not full
//   replay_cnt_o         deq handshakes from the saved beat, saturating
//   err_partial_mask_o   sticky: a beat with a non-full mask was captured
module tl_a_repeater #(
   parameter int unsigned ADDR_W = 30,
   parameter int unsigned SRC_W  = 7,
   parameter int unsigned SIZE_W = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  repeat_i,
   input  logic                  enq_valid_i,
   output logic                  enq_ready_o,
   input  logic [2:0]            enq_opcode_i,
   input  logic [2:0]            enq_param_i,
   input  logic [SIZE_W-1:0]     enq_size_i,
   input  logic [SRC_W-1:0]      enq_source_i,
   input  logic [ADDR_W-1:0]     enq_address_i,
   input  logic [DATA_W/8-1:0]   enq_mask_i,
   input  logic [DATA_W-1:0]     enq_data_i,
   input  logic                  enq_corrupt_i,
   output logic                  deq_valid_o,
   input  logic                  deq_ready_i,
   output logic [2:0]            deq_opcode_o,
   output logic [2:0]            deq_param_o,
   output logic [SIZE_W-1:0]     deq_size_o,
   output logic [SRC_W-1:0]      deq_source_o,
   output logic [ADDR_W-1:0]     deq_address_o,
   output logic [DATA_W/8-1:0]   deq_mask_o,
   output logic [DATA_W-1:0]     deq_data_o,
   output logic                  deq_corrupt_o,
   output logic                  full_o,
   output logic [DATA_W/8-1:0]   saved_mask_o,
   output logic [CNT_W-1:0]      replay_cnt_o,
   output logic                  err_partial_mask_o
);

   localparam int unsigned MASK_W = DATA_W / 8;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic                state_q,   state_d;
   logic [2:0]          opcode_q,  opcode_d;
   logic [2:0]          param_q,   param_d;
   logic [SIZE_W-1:0]   size_q,    size_d;
   logic [SRC_W-1:0]    source_q,  source_d;
   logic [ADDR_W-1:0]   address_q, address_d;
   logic [MASK_W-1:0]   mask_q,    mask_d;
   logic [DATA_W-1:0]   data_q,    data_d;
   logic                corrupt_q, corrupt_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic                err_q,     err_d;
   logic                deq_fire;
   logic [CNT_W-1:0]    cnt_inc;

   assign full_o             = (state_q == ST_FULL);
   assign deq_valid_o        = full_o ? 1'b1 : enq_valid_i;
   assign enq_ready_o        = full_o ? 1'b0 : deq_ready_i;
   assign deq_opcode_o       = full_o ? opcode_q  : enq_opcode_i;
   assign deq_param_o        = full_o ? param_q   : enq_param_i;
   assign deq_size_o         = full_o ? size_q    : enq_size_i;
   assign deq_source_o       = full_o ? source_q  : enq_source_i;
   assign deq_address_o      = full_o ? address_q : enq_address_i;
   assign deq_mask_o         = full_o ? mask_q    : enq_mask_i;
   assign deq_data_o         = full_o ? data_q    : enq_data_i;
   assign deq_corrupt_o      = full_o ? corrupt_q : enq_corrupt_i;
   assign saved_mask_o       = full_o ? mask_q    : '0;
   assign replay_cnt_o       = cnt_q;
   assign err_partial_mask_o = err_q;

   assign deq_fire = deq_valid_o & deq_ready_i;
   // Saturating increment: holds at all-ones.
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      param_d   = param_q;
      size_d    = size_q;
      source_d  = source_q;
      address_d = address_q;
      mask_d    = mask_q;
      data_d    = data_q;
      corrupt_d = corrupt_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      if (deq_fire) begin
         case (state_q)
            ST_EMPTY: begin
               if (repeat_i) begin
                  state_d   = ST_FULL;
                  opcode_d  = enq_opcode_i;
                  param_d   = enq_param_i;
                  size_d    = enq_size_i;
                  source_d  = enq_source_i;
                  address_d = enq_address_i;
                  mask_d    = enq_mask_i;
                  data_d    = enq_data_i;
                  corrupt_d = enq_corrupt_i;
                  cnt_d     = '0;
                  if (enq_mask_i != '1) err_d = 1'b1;
               end
            end
            default: begin
               cnt_d = cnt_inc;
               if (!repeat_i) state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_EMPTY;
         opcode_q  <= '0;
         param_q   <= '0;
         size_q    <= '0;
         source_q  <= '0;
         address_q <= '0;
         mask_q    <= '0;
         data_q    <= '0;
         corrupt_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         param_q   <= param_d;
         size_q    <= size_d;
         source_q  <= source_d;
         address_q <= address_d;
         mask_q    <= mask_d;
         data_q    <= data_d;
         corrupt_q <= corrupt_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_tl_a_repeater.sv
module tb_tl_a_repeater;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [2:0]  param;
      logic [3:0]  size;
      logic [6:0]  source;
      logic [29:0] address;
      logic [3:0]  mask;
      logic [31:0] data;
      logic        corrupt;
   } beat_t;

   typedef struct {
      logic        v, r, rp;
      logic [29:0] addr;
      logic [6:0]  src;
      logic [29:0] exp_addr;
      logic [6:0]  exp_src;
      logic        exp_enq_ready;
      logic        exp_full;
      int          exp_cnt;
   } vec_t;

   logic  clk = 1'b0;
   logic  rst_n, rep, vld, rdy;
   beat_t b_in;

   logic        d1_enq_ready, d1_deq_valid, d1_corrupt, d1_full, d1_err;
   logic [2:0]  d1_opcode, d1_param;
   logic [3:0]  d1_size, d1_mask, d1_smask;
   logic [6:0]  d1_source;
   logic [29:0] d1_address;
   logic [31:0] d1_data;
   logic [7:0]  d1_cnt;

   logic        d2_enq_ready, d2_deq_valid, d2_corrupt, d2_full, d2_err;
   logic [2:0]  d2_opcode, d2_param;
   logic [3:0]  d2_size, d2_mask, d2_smask;
   logic [6:0]  d2_source;
   logic [29:0] d2_address;
   logic [31:0] d2_data;
   logic [1:0]  d2_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic  m_full;
   beat_t m_saved;
   int    m_cnt;
   logic  m_err;

   always #5 clk = ~clk;

   tl_a_repeater u_dut (
      .clock_i(clk), .reset_n_i(rst_n), .repeat_i(rep),
      .enq_valid_i(vld), .enq_ready_o(d1_enq_ready),
      .enq_opcode_i(b_in.opcode), .enq_param_i(b_in.param), .enq_size_i(b_in.size),
      .enq_source_i(b_in.source), .enq_address_i(b_in.address), .enq_mask_i(b_in.mask),
      .enq_data_i(b_in.data), .enq_corrupt_i(b_in.corrupt),
      .deq_valid_o(d1_deq_valid), .deq_ready_i(rdy),
      .deq_opcode_o(d1_opcode), .deq_param_o(d1_param), .deq_size_o(d1_size),
      .deq_source_o(d1_source), .deq_address_o(d1_address), .deq_mask_o(d1_mask),
      .deq_data_o(d1_data), .deq_corrupt_o(d1_corrupt),
      .full_o(d1_full), .saved_mask_o(d1_smask), .replay_cnt_o(d1_cnt),
      .err_partial_mask_o(d1_err)
   );

   tl_a_repeater #(.CNT_W(2)) u_dut_sat (
      .clock_i(clk), .reset_n_i(rst_n), .repeat_i(rep),
      .enq_valid_i(vld), .enq_ready_o(d2_enq_ready),
      .enq_opcode_i(b_in.opcode), .enq_param_i(b_in.param), .enq_size_i(b_in.size),
      .enq_source_i(b_in.source), .enq_address_i(b_in.address), .enq_mask_i(b_in.mask),
      .enq_data_i(b_in.data), .enq_corrupt_i(b_in.corrupt),
      .deq_valid_o(d2_deq_valid), .deq_ready_i(rdy),
      .deq_opcode_o(d2_opcode), .deq_param_o(d2_param), .deq_size_o(d2_size),
      .deq_source_o(d2_source), .deq_address_o(d2_address), .deq_mask_o(d2_mask),
      .deq_data_o(d2_data), .deq_corrupt_o(d2_corrupt),
      .full_o(d2_full), .saved_mask_o(d2_smask), .replay_cnt_o(d2_cnt),
      .err_partial_mask_o(d2_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int clip(input int v, input int hi);
      return (v > hi) ? hi : v;
   endfunction

   function automatic beat_t mk(input logic [29:0] a, input logic [6:0] s, input logic [3:0] m);
      beat_t b;
      b = '0;
      b.opcode = 3'd4; b.size = 4'd2; b.address = a; b.source = s; b.mask = m;
      b.data = {2'b0, a} ^ 32'hA5A5_0000;
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.opcode  = 3'($urandom);
      b.param   = 3'($urandom);
      b.size    = 4'($urandom);
      b.source  = 7'($urandom);
      b.address = 30'($urandom);
      b.mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      b.data    = $urandom;
      b.corrupt = 1'($urandom);
      return b;
   endfunction

   // Expected outputs derived from the model: replaying shows the saved beat
   // and blocks upstream, otherwise the channel is a wire.
   task automatic model_check();
      beat_t e;
      e = m_full ? m_saved : b_in;
      chk("deq_valid",   d1_deq_valid, m_full ? 1'b1 : vld);
      chk("enq_ready",   d1_enq_ready, m_full ? 1'b0 : rdy);
      chk("deq_beat",    {d1_opcode, d1_param, d1_size, d1_source, d1_address, d1_mask, d1_data, d1_corrupt}, 64'(e));
      chk("deq_beat_hi", 64'({d1_opcode, d1_param, d1_size, d1_source, d1_address, d1_mask, d1_data, d1_corrupt} >> 64), 64'(e >> 64));
      chk("full",        d1_full, m_full);
      chk("saved_mask",  d1_smask, m_full ? m_saved.mask : 4'h0);
      chk("replay_cnt",  d1_cnt, clip(m_cnt, 255));
      chk("err_partial", d1_err, m_err);
      chk("sat_full",    d2_full, m_full);
      chk("sat_cnt",     d2_cnt, clip(m_cnt, 3));
      chk("sat_addr",    d2_address, e.address);
   endtask

   task automatic model_update();
      logic fire;
      fire = (m_full | vld) & rdy;
      if (!rst_n) begin
         m_full = 0; m_saved = '0; m_cnt = 0; m_err = 0;
      end else if (fire) begin
         if (!m_full) begin
            if (rep) begin
               m_full = 1; m_saved = b_in; m_cnt = 0;
               if (b_in.mask != 4'hF) m_err = 1;
            end
         end else begin
            m_cnt = m_cnt + 1;
            if (!rep) m_full = 0;
         end
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic rp, input logic rn, input beat_t b);
      vld = v; rdy = r; rep = rp; rst_n = rn; b_in = b;
      #1;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   vec_t vt[5];

   initial begin
      m_full = 0; m_saved = '0; m_cnt = 0; m_err = 0;
      vld = 0; rdy = 0; rep = 0; rst_n = 0; b_in = '0;
      @(negedge clk);
      // reset: model begins in its reset state
      rst_n = 0; tick();
      drive(0, 0, 0, 0, '0); tick();

      // Pass-through
      drive(1, 1, 0, 1, mk(30'h1000, 7'd1, 4'hF));
      chk("pt_addr", d1_address, 30'h1000);
      chk("pt_enq_ready", d1_enq_ready, 1'b1);
      tick();
      chk("pt_full_after", d1_full, 1'b0);

      // Capture and replay, table driven
      vt[0] = '{1, 1, 1, 30'h2000, 7'd5, 30'h2000, 7'd5, 1, 0, 0};
      vt[1] = '{1, 1, 1, 30'h3000, 7'd9, 30'h2000, 7'd5, 0, 1, 0};
      vt[2] = '{1, 1, 1, 30'h3000, 7'd9, 30'h2000, 7'd5, 0, 1, 1};
      vt[3] = '{1, 1, 0, 30'h3000, 7'd9, 30'h2000, 7'd5, 0, 1, 2};
      vt[4] = '{1, 1, 0, 30'h3000, 7'd9, 30'h3000, 7'd9, 1, 0, 3};
      foreach (vt[i]) begin
         drive(vt[i].v, vt[i].r, vt[i].rp, 1, mk(vt[i].addr, vt[i].src, 4'hF));
         chk($sformatf("tbl%0d_addr", i), d1_address, vt[i].exp_addr);
         chk($sformatf("tbl%0d_src", i), d1_source, vt[i].exp_src);
         chk($sformatf("tbl%0d_enq_ready", i), d1_enq_ready, vt[i].exp_enq_ready);
         chk($sformatf("tbl%0d_full", i), d1_full, vt[i].exp_full);
         chk($sformatf("tbl%0d_cnt", i), d1_cnt, vt[i].exp_cnt);
         tick();
      end

      // Backpressure while full
      drive(1, 1, 1, 1, mk(30'h4000, 7'd3, 4'hF)); tick();
      drive(1, 1, 1, 1, mk(30'h4100, 7'd4, 4'hF)); tick();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, 1, mk(30'h5000 + 30'(i), 7'd6, 4'hF));
         chk("bp_valid", d1_deq_valid, 1'b1);
         chk("bp_addr", d1_address, 30'h4000);
         tick();
         chk("bp_cnt", d1_cnt, 8'd1);
      end
      drive(1, 1, 0, 1, mk(30'h5000, 7'd6, 4'hF)); tick();
      chk("bp_release", d1_full, 1'b0);

      // Partial mask
      chk("pm_err_before", d1_err, 1'b0);
      drive(1, 1, 1, 1, mk(30'h6000, 7'd7, 4'h3)); tick();
      chk("pm_err_set", d1_err, 1'b1);
      chk("pm_smask_full", d1_smask, 4'h3);
      drive(1, 1, 0, 1, mk(30'h6100, 7'd7, 4'hF)); tick();
      chk("pm_err_sticky", d1_err, 1'b1);
      chk("pm_smask_empty", d1_smask, 4'h0);

      // Saturation on the 2-bit counter instance
      drive(1, 1, 1, 1, mk(30'h7000, 7'd8, 4'hF)); tick();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 1, 1, mk(30'h7100, 7'd8, 4'hF)); tick();
         chk($sformatf("sat_read%0d", i), d2_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
      end
      drive(1, 1, 0, 1, mk(30'h7100, 7'd8, 4'hF)); tick();

      // Reset mid-replay
      drive(1, 1, 1, 1, mk(30'h8000, 7'd2, 4'h1)); tick();
      drive(1, 1, 1, 1, mk(30'h8100, 7'd2, 4'hF)); tick();
      chk("rst_pre_full", d1_full, 1'b1);
      drive(1, 0, 0, 0, mk(30'h8200, 7'd2, 4'hF)); tick();
      drive(1, 1, 0, 1, mk(30'h9000, 7'd11, 4'hF));
      chk("rst_full", d1_full, 1'b0);
      chk("rst_cnt", d1_cnt, 8'd0);
      chk("rst_err", d1_err, 1'b0);
      chk("rst_pass_addr", d1_address, 30'h9000);
      chk("rst_pass_src", d1_source, 7'd11);
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) != 0), rand_beat());
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_a_repeater.md
# tl_a_repeater

Single-entry TileLink A-channel repeater between the A-channel source (fragmenter/width-adapter control) and the A-channel consumer that the TL monitor/assertion stage observes. In pass-through mode it forwards beats combinationally. When the upstream controller raises `repeat` on an accepted beat, it captures that beat and re-presents it until a non-repeat handshake releases it. It also provides the `full` and saved-mask status that the downstream assertion stage checks.

## Interface
- `ADDR_W`, default 30: A-channel address width.
- `SRC_W`, default 7: source ID width.
- `SIZE_W`, default 4: log2 transfer-size field width.
- `DATA_W`, default 32: data width; `MASK_W` = `DATA_W/8`, derived, not overridable.
- `CNT_W`, default 8: replay counter width.

Ports:
- `clock` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `repeat` in 1: hold the current beat for replay; sampled only on a deq handshake.
- `enq_valid` in 1 / `enq_ready` out 1: upstream handshake.
- `enq_opcode` in 3, `enq_param` in 3, `enq_size` in SIZE_W, `enq_source` in SRC_W, `enq_address` in ADDR_W, `enq_mask` in MASK_W, `enq_data` in DATA_W, `enq_corrupt` in 1: upstream beat fields.
- `deq_valid` out 1 / `deq_ready` in 1: downstream handshake.
- `deq_opcode`, `deq_param`, `deq_size`, `deq_source`, `deq_address`, `deq_mask`, `deq_data`, `deq_corrupt`: out, widths as the enq fields.
- `full` out 1: a captured beat is being replayed.
- `saved_mask` out MASK_W: mask of the captured beat; 0 when not full.
- `replay_cnt` out CNT_W: deq handshakes issued from the saved beat since capture; saturates at all-ones.
- `err_partial_mask` out 1: sticky. Set when a beat is captured with a mask that is not all-ones.

## Operation
- Define `deq_fire = deq_valid & deq_ready` and `enq_fire = enq_valid & enq_ready`.
- Not full (pass-through):
  - `deq_valid = enq_valid`, `enq_ready = deq_ready`.
  - All deq fields equal the enq fields combinationally.
- Full (replay):
  - `deq_valid = 1`, `enq_ready = 0`.
  - Deq fields come from the saved registers. Enq fields are ignored.
- State transitions (evaluated on each deq_fire):
  - EMPTY→FULL on `deq_fire & repeat & !full`. Capture all enq fields into the saved registers and set `replay_cnt = 0`.
  - FULL→FULL on `deq_fire & repeat & full`. Saved fields are unchanged; `replay_cnt` increments and saturates.
  - FULL→EMPTY on `deq_fire & !repeat & full`. The final replay beat is issued; `replay_cnt` increments and saturates.
  - Nothing changes without a deq_fire.
- `err_partial_mask` is set on the EMPTY→FULL capture when `enq_mask != all-ones`. It clears only on reset.
- `saved_mask` reads the saved mask register while full; otherwise it is forced to 0.
- The block does not check `repeat` when there is no handshake. `repeat` high with `deq_ready` low has no effect.

## Timing
- Pass-through path is zero latency and purely combinational (enq→deq fields, `deq_ready`→`enq_ready`).
- `full` is registered and takes effect the cycle after the capturing deq_fire. From that cycle, `enq_ready` is 0 and deq shows the saved beat.
- Release: after the final (non-repeat) replay deq_fire, `full` = 0 in the next cycle and pass-through resumes the same cycle.
- Minimum occupancy is 1 cycle: capture beat, then one replay handshake with `repeat=0`.
- Reset (`reset_n = 0` at an edge):
  - `full = 0`, saved fields = 0, `replay_cnt = 0`, `err_partial_mask = 0`.
  - Reset mid-replay discards the saved beat. The next cycle is pass-through.
- Outputs during reset follow the combinational rules with `full = 0`.

## Test plan
- Pass-through:
  - Drive `enq_valid = 1`, `address = 0x1000`, `mask = 0xF`, `repeat = 0`, `deq_ready = 1`.
  - Required: deq shows the same beat in the same cycle; `enq_ready = 1`; `full` stays 0.
- Capture and replay:
  - Accept a beat with `address = 0x2000`, `source = 5`, `repeat = 1`. Then drive `enq_address = 0x3000` with `repeat = 1` for 2 more handshakes, then `repeat = 0`.
  - Required: deq shows `0x2000` for 3 replay beats; `enq_ready = 0` throughout; `replay_cnt` reads 1, 2, 3; `full` = 0 after the last beat.
- Backpressure while full:
  - Hold `deq_ready = 0` for 5 cycles while full.
  - Required: `deq_valid = 1`, saved fields stable, `replay_cnt` unchanged.
- Partial mask:
  - Capture a beat with `mask = 0x3`.
  - Required: `err_partial_mask = 1` next cycle; it stays 1 after release; `saved_mask = 0x3` while full and 0 after release.
- Saturation:
  - With `CNT_W = 2`, replay 6 times.
  - Required: `replay_cnt` reads 1, 2, 3, 3, 3, 3.
- Reset mid-replay:
  - Assert `reset_n = 0` for 1 cycle while full.
  - Required: next cycle `full = 0`, `replay_cnt = 0`, `err_partial_mask = 0`, and a new enq beat passes through unchanged.
